// File: rtl/gb_alu_pkg.sv
// gb_alu_pkg: shared opcode encodings, flag bit positions and small helpers for the
// SM83-style ALU (gb_alu) and its DAA correction block (gb_alu_daa).
// Flags are packed {Z,N,H,C} in bits [3:0].
package gb_alu_pkg;

  // 8-bit arithmetic / logic
  localparam logic [7:0] ALU_ADD   = 8'h00;
  localparam logic [7:0] ALU_ADC   = 8'h01;
  localparam logic [7:0] ALU_SUB   = 8'h02;
  localparam logic [7:0] ALU_SBC   = 8'h03;
  localparam logic [7:0] ALU_AND   = 8'h04;
  localparam logic [7:0] ALU_XOR   = 8'h05;
  localparam logic [7:0] ALU_OR    = 8'h06;
  localparam logic [7:0] ALU_CP    = 8'h07;
  // Rotates and flag ops
  localparam logic [7:0] ALU_RLC   = 8'h08;
  localparam logic [7:0] ALU_RRC   = 8'h09;
  localparam logic [7:0] ALU_RL    = 8'h0A;
  localparam logic [7:0] ALU_RR    = 8'h0B;
  localparam logic [7:0] ALU_DAA   = 8'h0C;
  localparam logic [7:0] ALU_CPL   = 8'h0D;
  localparam logic [7:0] ALU_SCF   = 8'h0E;
  localparam logic [7:0] ALU_CCF   = 8'h0F;
  // Shifts, swap, 16-bit add
  localparam logic [7:0] ALU_SLA   = 8'h10;
  localparam logic [7:0] ALU_SRA   = 8'h11;
  localparam logic [7:0] ALU_SRL   = 8'h12;
  localparam logic [7:0] ALU_SWAP  = 8'h13;
  localparam logic [7:0] ALU_ADD16 = 8'h14;
  // Bit ops: base opcode, bit index n in op[2:0]
  localparam logic [7:0] ALU_BIT   = 8'h18;
  localparam logic [7:0] ALU_RES   = 8'h20;
  localparam logic [7:0] ALU_SET   = 8'h28;

  // Flag bit positions within the {Z,N,H,C} nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  function automatic logic is_zero(input logic [7:0] v);
    return (v == 8'h00);
  endfunction

endpackage

// File: rtl/gb_alu_daa.sv
// gb_alu_daa: combinational SM83 decimal-adjust correction.
// Ports:
//   i_a   - accumulator value to adjust
//   i_n   - incoming N flag (last op was a subtraction)
//   i_h   - incoming H flag
//   i_c   - incoming C flag
//   o_res - adjusted value
//   o_c   - resulting C flag (set on +0x60 after an add, preserved after a subtract)
module gb_alu_daa
  import gb_alu_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic       i_n,
  input  logic       i_h,
  input  logic       i_c,
  output logic [7:0] o_res,
  output logic       o_c
);

  logic [7:0] w_corr;

  always_comb begin
    w_corr = 8'h00;
    o_c    = i_c;
    o_res  = i_a;
    if (!i_n) begin
      // Both tests look at the unadjusted input value
      if (i_h || (i_a[3:0] > 4'd9)) begin
        w_corr = w_corr | 8'h06;
      end
      if (i_c || (i_a > 8'h99)) begin
        w_corr = w_corr | 8'h60;
        o_c    = 1'b1;
      end
      o_res = i_a + w_corr;
    end else begin
      if (i_h) begin
        w_corr = w_corr | 8'h06;
      end
      if (i_c) begin
        w_corr = w_corr | 8'h60;
      end
      o_res = i_a - w_corr;
    end
  end

endmodule

// File: rtl/gb_alu.sv
// gb_alu: SM83 (Game Boy) ALU with a one-cycle registered result.
// Every cycle the op/X/Y/F inputs are decoded by a single case statement and the
// result is captured on the rising clock edge.
// Ports:
//   clk     - clock, all state on rising edge
//   rst_n   - asynchronous active-low reset, clears O and FResult
//   op      - 8-bit operation code (see gb_alu_pkg)
//   X, Y    - 16-bit operands (8-bit ops use bits [7:0])
//   F       - incoming flags {Z,N,H,C}
//   FResult - registered resulting flags {Z,N,H,C}
//   O       - registered 16-bit result
// Configuration: define ALU_ADD16_EN to implement ADD16 (opcode 0x14); otherwise that
// opcode falls through to the undefined-opcode behaviour and no 16-bit adder exists.
module gb_alu
  import gb_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  op,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic [3:0]  F,
  output logic [3:0]  FResult,
  output logic [15:0] O
);

  logic        w_cin;
  logic [8:0]  w_add8;
  logic [4:0]  w_add4;
  logic [8:0]  w_sub8;
  logic [4:0]  w_sub4;
  logic [7:0]  w_res;
  logic [7:0]  w_mask;
  logic [7:0]  w_daa_res;
  logic        w_daa_c;
  logic [15:0] w_o;
  logic [3:0]  w_f;
  logic [15:0] r_o;
  logic [3:0]  r_f;

  // Carry-in only for ADC/SBC; CP behaves as a plain SUB
  assign w_cin  = ((op == ALU_ADC) || (op == ALU_SBC)) ? F[FLAG_C] : 1'b0;
  assign w_add8 = {1'b0, X[7:0]} + {1'b0, Y[7:0]} + {8'h00, w_cin};
  assign w_add4 = {1'b0, X[3:0]} + {1'b0, Y[3:0]} + {4'h0, w_cin};
  // Bit 8 / bit 4 of the widened difference is the borrow
  assign w_sub8 = {1'b0, X[7:0]} - {1'b0, Y[7:0]} - {8'h00, w_cin};
  assign w_sub4 = {1'b0, X[3:0]} - {1'b0, Y[3:0]} - {4'h0, w_cin};
  assign w_mask = 8'h01 << op[2:0];

`ifdef ALU_ADD16_EN
  logic [16:0] w_add16;
  logic [12:0] w_add12;
  assign w_add16 = {1'b0, X} + {1'b0, Y};
  assign w_add12 = {1'b0, X[11:0]} + {1'b0, Y[11:0]};
`else
  logic unused_y_hi;
  assign unused_y_hi = ^Y[15:8];
`endif

  gb_alu_daa u_daa (
    .i_a   (X[7:0]),
    .i_n   (F[FLAG_N]),
    .i_h   (F[FLAG_H]),
    .i_c   (F[FLAG_C]),
    .o_res (w_daa_res),
    .o_c   (w_daa_c)
  );

  always_comb begin
    // Undefined opcodes pass X and F through
    w_o   = X;
    w_f   = F;
    w_res = 8'h00;
    case (op) inside
      ALU_ADD, ALU_ADC: begin
        w_res = w_add8[7:0];
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 1'b0, w_add4[4], w_add8[8]};
      end
      ALU_SUB, ALU_SBC: begin
        w_res = w_sub8[7:0];
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 1'b1, w_sub4[4], w_sub8[8]};
      end
      ALU_CP: begin
        w_res = w_sub8[7:0];
        w_o   = {8'h00, X[7:0]};
        w_f   = {is_zero(w_res), 1'b1, w_sub4[4], w_sub8[8]};
      end
      ALU_AND: begin
        w_res = X[7:0] & Y[7:0];
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 1'b0, 1'b1, 1'b0};
      end
      ALU_XOR: begin
        w_res = X[7:0] ^ Y[7:0];
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 3'b000};
      end
      ALU_OR: begin
        w_res = X[7:0] | Y[7:0];
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 3'b000};
      end
      ALU_RLC: begin
        w_res = {X[6:0], X[7]};
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 2'b00, X[7]};
      end
      ALU_RRC: begin
        w_res = {X[0], X[7:1]};
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 2'b00, X[0]};
      end
      ALU_RL: begin
        w_res = {X[6:0], F[FLAG_C]};
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 2'b00, X[7]};
      end
      ALU_RR: begin
        w_res = {F[FLAG_C], X[7:1]};
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 2'b00, X[0]};
      end
      ALU_DAA: begin
        w_res = w_daa_res;
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), F[FLAG_N], 1'b0, w_daa_c};
      end
      ALU_CPL: begin
        w_res = ~X[7:0];
        w_o   = {8'h00, w_res};
        w_f   = {F[FLAG_Z], 1'b1, 1'b1, F[FLAG_C]};
      end
      ALU_SCF: begin
        w_o = {8'h00, X[7:0]};
        w_f = {F[FLAG_Z], 3'b001};
      end
      ALU_CCF: begin
        w_o = {8'h00, X[7:0]};
        w_f = {F[FLAG_Z], 2'b00, ~F[FLAG_C]};
      end
      ALU_SLA: begin
        w_res = {X[6:0], 1'b0};
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 2'b00, X[7]};
      end
      ALU_SRA: begin
        w_res = {X[7], X[7:1]};
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 2'b00, X[0]};
      end
      ALU_SRL: begin
        w_res = {1'b0, X[7:1]};
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 2'b00, X[0]};
      end
      ALU_SWAP: begin
        w_res = {X[3:0], X[7:4]};
        w_o   = {8'h00, w_res};
        w_f   = {is_zero(w_res), 3'b000};
      end
`ifdef ALU_ADD16_EN
      ALU_ADD16: begin
        w_o = w_add16[15:0];
        w_f = {F[FLAG_Z], 1'b0, w_add12[12], w_add16[16]};
      end
`endif
      [ALU_BIT : ALU_BIT + 8'd7]: begin
        w_o = {8'h00, X[7:0]};
        w_f = {~X[op[2:0]], 1'b0, 1'b1, F[FLAG_C]};
      end
      [ALU_RES : ALU_RES + 8'd7]: begin
        w_res = X[7:0] & ~w_mask;
        w_o   = {8'h00, w_res};
        w_f   = F;
      end
      [ALU_SET : ALU_SET + 8'd7]: begin
        w_res = X[7:0] | w_mask;
        w_o   = {8'h00, w_res};
        w_f   = F;
      end
      default: begin
        w_o = X;
        w_f = F;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o <= 16'h0000;
      r_f <= 4'h0;
    end else begin
      r_o <= w_o;
      r_f <= w_f;
    end
  end

  assign O       = r_o;
  assign FResult = r_f;

endmodule

// File: tb/tb_gb_alu.sv
module tb_gb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  op = 8'h00;
  logic [15:0] X = 16'h0000;
  logic [15:0] Y = 16'h0000;
  logic [3:0]  F = 4'h0;
  logic [3:0]  FResult;
  logic [15:0] O;

  gb_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (op),
    .X       (X),
    .Y       (Y),
    .F       (F),
    .FResult (FResult),
    .O       (O)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  f;
    logic [15:0] eo;
    logic [3:0]  ef;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  function automatic void add(input string name, input logic [7:0] o_p, input logic [15:0] x,
                              input logic [15:0] y, input logic [3:0] f,
                              input logic [15:0] eo, input logic [3:0] ef);
    vec_t v;
    v.name = name; v.op = o_p; v.x = x; v.y = y; v.f = f; v.eo = eo; v.ef = ef;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    op = v.op; X = v.x; Y = v.y; F = v.f;
    sb.push_back({v.eo, v.ef});
  endtask

  task automatic check(input string name);
    logic [19:0] e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_mis++;
      $display("FAIL %s: scoreboard empty, got O=%h FResult=%b", name, O, FResult);
    end else begin
      e = sb.pop_front();
      if ({O, FResult} !== e) begin
        n_mis++;
        $display("FAIL %s: got O=%h FResult=%b, expected O=%h FResult=%b",
                 name, O, FResult, e[19:4], e[3:0]);
      end
    end
  endtask

  initial begin
    // name, op, X, Y, F, expected O, expected FResult {Z,N,H,C}
    add("add_zero",   8'h00, 16'h003A, 16'h00C6, 4'b0000, 16'h0000, 4'b1011);
    add("add_hi_ign", 8'h00, 16'h12FF, 16'h3401, 4'b0000, 16'h0000, 4'b1011);
    add("adc_half",   8'h01, 16'h000F, 16'h0000, 4'b0001, 16'h0010, 4'b0010);
    add("sub_zero",   8'h02, 16'h003E, 16'h003E, 4'b0000, 16'h0000, 4'b1100);
    add("cp_eq",      8'h07, 16'h003E, 16'h003E, 4'b0000, 16'h003E, 4'b1100);
    add("sbc_half",   8'h03, 16'h0010, 16'h0001, 4'b0001, 16'h000E, 4'b0110);
    add("sub_wrap",   8'h02, 16'h0000, 16'h0001, 4'b0000, 16'h00FF, 4'b0111);
    add("and_zero",   8'h04, 16'h00F0, 16'h000F, 4'b0000, 16'h0000, 4'b1010);
    add("xor",        8'h05, 16'h00FF, 16'h000F, 4'b1111, 16'h00F0, 4'b0000);
    add("or_zero",    8'h06, 16'h0000, 16'h0000, 4'b0111, 16'h0000, 4'b1000);
    add("rlc",        8'h08, 16'h0085, 16'h0000, 4'b0000, 16'h000B, 4'b0001);
    add("rrc",        8'h09, 16'h0001, 16'h0000, 4'b0000, 16'h0080, 4'b0001);
    add("rl_zero",    8'h0A, 16'h0080, 16'h0000, 4'b0000, 16'h0000, 4'b1001);
    add("rr_cin",     8'h0B, 16'h0001, 16'h0000, 4'b0001, 16'h0080, 4'b0001);
    add("sla",        8'h10, 16'h0080, 16'h0000, 4'b0000, 16'h0000, 4'b1001);
    add("sra",        8'h11, 16'h0081, 16'h0000, 4'b0000, 16'h00C0, 4'b0001);
    add("srl",        8'h12, 16'h0001, 16'h0000, 4'b0000, 16'h0000, 4'b1001);
    add("swap",       8'h13, 16'h00F0, 16'h0000, 4'b0000, 16'h000F, 4'b0000);
    add("daa_low",    8'h0C, 16'h007D, 16'h0000, 4'b0000, 16'h0083, 4'b0000);
    add("daa_both",   8'h0C, 16'h009A, 16'h0000, 4'b0000, 16'h0000, 4'b1001);
    add("daa_sub",    8'h0C, 16'h000F, 16'h0000, 4'b0110, 16'h0009, 4'b0100);
    add("cpl",        8'h0D, 16'h0035, 16'h0000, 4'b1001, 16'h00CA, 4'b1111);
    add("scf",        8'h0E, 16'h0012, 16'h0000, 4'b0110, 16'h0012, 4'b0001);
    add("ccf",        8'h0F, 16'h0012, 16'h0000, 4'b1001, 16'h0012, 4'b1000);
`ifdef ALU_ADD16_EN
    add("add16",      8'h14, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
`else
    add("add16_off",  8'h14, 16'h0FFF, 16'h0001, 4'b1000, 16'h0FFF, 4'b1000);
`endif
    add("bit7",       8'h1F, 16'h007F, 16'h0000, 4'b0001, 16'h007F, 4'b1011);
    add("bit0",       8'h18, 16'h0001, 16'h0000, 4'b1000, 16'h0001, 4'b0010);
    add("set3",       8'h2B, 16'h0000, 16'h0000, 4'b0101, 16'h0008, 4'b0101);
    add("res7",       8'h27, 16'h00FF, 16'h0000, 4'b1010, 16'h007F, 4'b1010);
    add("undef_30",   8'h30, 16'hABCD, 16'h1111, 4'b0110, 16'hABCD, 4'b0110);
    add("undef_15",   8'h15, 16'h1234, 16'h0000, 4'b0011, 16'h1234, 4'b0011);

    // Reset state, with operands that would otherwise give a nonzero result
    op = 8'h06; X = 16'h00FF; Y = 16'h0000; F = 4'b1111;
    #1;
    sb.push_back(20'h0); check("reset_initial");
    @(posedge clk); #1;
    sb.push_back(20'h0); check("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: one vector per cycle, checked #1 after the capturing edge
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check(vecs[i].name);
      @(negedge clk);
    end

    // Asynchronous reset mid-operation during RL
    op = 8'h0A; X = 16'h0080; Y = 16'h0000; F = 4'b0001;
    sb.push_back({16'h0001, 4'b0001});
    @(posedge clk); #1;
    check("rl_before_reset");
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(20'h0); check("async_reset");
    @(posedge clk); #1;
    sb.push_back(20'h0); check("reset_hold_edge");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sb.push_back(20'h0); check("release_no_edge");
    @(posedge clk); #1;
    sb.push_back({16'h0001, 4'b0001}); check("resume_after_release");

    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
